scramble_ctrl: RTL and testbench
================================

# scramble_ctrl

Sequencing controller for the scrambler/checker pair. On request it seeds the scrambler, holds the checker's `ready` asserted until a validated permutation arrives, and captures the six indices. It then hands them to a consumer one at a time with a valid/next handshake. It supervises the scrambler with a timeout and a range check, and sits between the game control FSM and the scrambler datapath.

## Interface
- `TIMEOUT`, default 64: maximum cycles in WAIT before error; legal range 2..255.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new permutation; honoured only in IDLE or ERR.
- `abort` input 1: return to IDLE from any state.
- `mode_in` input 2: scramble mode, latched on accepted `start`.
- `next` input 1: consumer accepts current `out_index`.
- `scr_done` input 1: checker reports a valid permutation.
- `scr_idx1`..`scr_idx6` input 3 each: checker's permutation outputs.
- `scr_index` output 3: seed index to scrambler.
- `scr_mode` output 2: mode to scrambler.
- `scr_ready` output 1: `ready` to checker.
- `out_index` output 3: current delivered index.
- `out_valid` output 1: `out_index` valid.
- `out_last` output 1: current index is slot 6.
- `busy` output 1: state is not IDLE or ERR.
- `err` output 1: timeout or range error; sticky.

## Operation
- States: IDLE, WAIT, DELIVER, ERR (2-bit encoding).
- Free-running seed counter `seed_r`: counts 0..5 every cycle, wraps 5→0, and keeps running in all states.
- IDLE: on `start`, latch `scr_index`←`seed_r` and `scr_mode`←`mode_in`, clear the timeout counter, go to WAIT. `err` is cleared on that accepted `start`.
- WAIT: `scr_ready`=1. The timeout counter increments each cycle.
  - On `scr_done`=1: capture `scr_idx1..6` into slots 0..5 and set `ptr`=0.
    - If any captured value >5, go to ERR.
    - Otherwise go to DELIVER.
  - If the counter reaches `TIMEOUT` with `scr_done`=0, go to ERR.
  - If `scr_done` and timeout occur in the same cycle, `scr_done` wins.
- DELIVER: `out_valid`=1, `out_index`=slot[`ptr`], `out_last`=(`ptr`==5).
  - `next`=1 with `ptr`<5: `ptr`+1.
  - `next`=1 with `ptr`==5: go to IDLE.
  - `next` while `out_valid`=0 is ignored.
- ERR: `err`=1 and `scr_ready`=0. A `start` behaves exactly as from IDLE.
- `start` in WAIT or DELIVER is ignored.
- `abort`: go to IDLE next cycle from any state and drop `scr_ready`/`out_valid`. Slots and `err` are unchanged. `abort` has priority over `start`, `scr_done` and `next` in the same cycle.
- `scr_index`/`scr_mode` hold their last latched value outside WAIT.

## Timing
- Reset values:
  - state IDLE; `seed_r`=0; `ptr`=0; slots=0.
  - All outputs 0: `scr_index`, `scr_mode`, `scr_ready`, `out_index`, `out_valid`, `out_last`, `busy`, `err`.
- `start` sampled at edge N: `scr_ready`, `busy`, and the new `scr_index`/`scr_mode` are visible after N (cycle N+1).
- `scr_done` sampled at edge M: `scr_ready`=0 and `out_valid`=1 with slot 0 from M+1. Latency is 1 cycle.
- Each `next` advances one slot per cycle. Full delivery takes a minimum of 6 cycles.
- The 6th `next` at edge K: `out_valid`=0 and `busy`=0 from K+1. A new `start` is accepted at K+1 at the earliest.
- Timeout: `scr_ready` stays high for exactly `TIMEOUT` cycles, and `err`=1 in the following cycle.
- Reset mid-operation: next cycle equals the reset state.

## Structure
- Package `scrambler_pkg`: state enum, `NUM_SLOTS`=6, `IDX_W`=3, `MODE_W`=2, `MAX_IDX`=5.
- One sub-module, `scramble_slot_buf`:
  - 6×3-bit register file with parallel load, range-check output, read pointer, and `last` flag.
  - The FSM, seed counter and timeout counter stay in the top level.

## Test plan
- Normal run: `start` with `mode_in`=2 while `seed_r`=3 → `scr_index`=3 and `scr_mode`=2. `scr_done` arrives with 4,0,5,1,3,2 → `out_index` 4,0,5,1,3,2 on six consecutive `next`; `out_last` on 2; `busy`=0 afterwards.
- Backpressure: hold `next`=0 for 10 cycles in DELIVER → `out_index` stays 4. Toggling `next` gives one step per high cycle.
- Timeout: `TIMEOUT`=8 and no `scr_done` → `scr_ready` high for 8 cycles, then `err`=1 and `busy`=0. A later `start` clears `err` and raises `scr_ready`.
- Range error: `scr_done` with `scr_idx3`=7 → ERR; `out_valid` never rises.
- Collisions: `abort`+`scr_done` in the same cycle → IDLE, no delivery. `start` during DELIVER is ignored and `ptr` is unchanged. `scr_done` on the timeout cycle → DELIVER, `err`=0.
- Reset in DELIVER at `ptr`=3 → all outputs 0 next cycle and `seed_r` restarts at 0.

Source files
------------

// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared types and sizes for the scramble controller and its slot buffer
package scrambler_pkg;
  localparam int NUM_SLOTS = 6;
  localparam int IDX_W = 3;
  localparam int MODE_W = 2;
  localparam logic [IDX_W-1:0] MAX_IDX = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DELIVER, S_ERR} state_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/scramble_slot_buf.sv
// scramble_slot_buf: six-entry index store with parallel load, range check and read pointer
module scramble_slot_buf
  import scrambler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   adv,
  input  idx_t [NUM_SLOTS-1:0]   din,
  output logic                   range_err,
  output idx_t                   idx,
  output logic                   last
);
  idx_t [NUM_SLOTS-1:0] slot;
  logic [2:0] ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      ptr <= '0;
    end else if (load) begin
      slot <= din;
      ptr <= '0;
    end else if (adv && !last) begin
      ptr <= ptr + 3'd1;
    end
  end
  // checks the incoming values so the FSM can route on the capture cycle itself
  always_comb begin
    range_err = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) range_err = range_err | (din[i] > MAX_IDX);
  end
  assign idx = slot[ptr];
  assign last = ptr == 3'(NUM_SLOTS - 1);
endmodule

// File: rtl/scramble_ctrl.sv
// scramble_ctrl: seeds the scrambler, waits for a checked permutation, delivers its six indices
module scramble_ctrl
  import scrambler_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              next,
  input  logic              scr_done,
  input  idx_t              scr_idx1,
  input  idx_t              scr_idx2,
  input  idx_t              scr_idx3,
  input  idx_t              scr_idx4,
  input  idx_t              scr_idx5,
  input  idx_t              scr_idx6,
  output idx_t              scr_index,
  output logic [MODE_W-1:0] scr_mode,
  output logic              scr_ready,
  output idx_t              out_index,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [2:0] seed_r;
  logic [7:0] cnt;
  logic accept, load, adv, range_err, last;
  idx_t idx;
  scramble_slot_buf u_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .adv(adv),
    .din({scr_idx6, scr_idx5, scr_idx4, scr_idx3, scr_idx2, scr_idx1}),
    .range_err(range_err),
    .idx(idx),
    .last(last)
  );
  // abort outranks every other event, and scr_done outranks the timeout
  always_comb begin
    accept = (state == S_IDLE || state == S_ERR) && start && !abort;
    load = state == S_WAIT && scr_done && !abort;
    adv = state == S_DELIVER && next && !abort;
    state_n = abort ? S_IDLE :
              accept ? S_WAIT :
              load ? (range_err ? S_ERR : S_DELIVER) :
              (state == S_WAIT && cnt == TMO_LAST) ? S_ERR :
              (adv && last) ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      seed_r <= '0;
      cnt <= '0;
      scr_index <= '0;
      scr_mode <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      seed_r <= seed_r == MAX_IDX ? 3'd0 : seed_r + 3'd1;
      cnt <= accept ? 8'd0 : state == S_WAIT ? cnt + 8'd1 : cnt;
      if (accept) begin
        scr_index <= seed_r;
        scr_mode <= mode_in;
      end
      err <= accept ? 1'b0 : state_n == S_ERR ? 1'b1 : err;
    end
  end
  assign scr_ready = state == S_WAIT;
  assign out_valid = state == S_DELIVER;
  assign out_index = out_valid ? idx : '0;
  assign out_last = out_valid && last;
  assign busy = scr_ready || out_valid;
endmodule

// File: tb/tb_scramble_ctrl.sv
// tb_scramble_ctrl: randomized scoreboard bench for scramble_ctrl with directed corner cases
module tb_scramble_ctrl;
  localparam int TMO = 8;
  logic clk = 0, rst = 1, start = 0, abort = 0, next = 0, scr_done = 0;
  logic [1:0] mode_in = 0;
  logic [2:0] si [6];
  logic [2:0] scr_index, out_index;
  logic [1:0] scr_mode;
  logic scr_ready, out_valid, out_last, busy, err;
  int checks = 0, errors = 0, cyc = 0;
  int exp_q[$];

  scramble_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_in(mode_in), .next(next),
    .scr_done(scr_done), .scr_idx1(si[0]), .scr_idx2(si[1]), .scr_idx3(si[2]),
    .scr_idx4(si[3]), .scr_idx5(si[4]), .scr_idx6(si[5]), .scr_index(scr_index),
    .scr_mode(scr_mode), .scr_ready(scr_ready), .out_index(out_index), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  // the seed is simply the number of cycles since reset, modulo six
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && next) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL delivery: unexpected index %0d, nothing expected", out_index);
      end else begin
        int e;
        e = exp_q.pop_front();
        if ({out_last, out_index} !== 4'(e)) begin
          errors++;
          $display("FAIL delivery: got last=%0d idx=%0d, expected last=%0d idx=%0d",
                   out_last, out_index, e / 8, e % 8);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_scr_index"}, int'(scr_index), 0);
    chk({tag, "_scr_mode"}, int'(scr_mode), 0);
    chk({tag, "_scr_ready"}, int'(scr_ready), 0);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic start_txn(input logic [1:0] m);
    int s;
    s = cyc % 6;
    start = 1;
    mode_in = m;
    tick();
    start = 0;
    chk("start_scr_index", int'(scr_index), s);
    chk("start_scr_mode", int'(scr_mode), int'(m));
    chk("start_scr_ready", int'(scr_ready), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_err", int'(err), 0);
  endtask

  task automatic done_txn(input int v[6]);
    bit bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      si[i] = 3'(v[i]);
      if (v[i] > 5) bad = 1;
    end
    if (!bad) for (int i = 0; i < 6; i++) exp_q.push_back(v[i] + (i == 5 ? 8 : 0));
    scr_done = 1;
    tick();
    scr_done = 0;
    chk("done_out_valid", int'(out_valid), int'(!bad));
    chk("done_err", int'(err), int'(bad));
    chk("done_scr_ready", int'(scr_ready), 0);
  endtask

  task automatic drain(input bit rnd, output int n);
    n = 0;
    while (out_valid && n < 200) begin
      next = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    next = 0;
    chk("drain_out_valid", int'(out_valid), 0);
    chk("drain_busy", int'(busy), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    int n, rose, d;
    int v[6];
    bit bad;
    for (int i = 0; i < 6; i++) si[i] = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 0;

    // normal run with seed 3 and mode 2
    while (cyc % 6 != 3) tick();
    start_txn(2);
    chk("normal_seed", int'(scr_index), 3);
    done_txn('{4, 0, 5, 1, 3, 2});
    chk("normal_first", int'(out_index), 4);
    drain(0, n);
    chk("normal_cycles", n, 6);

    // backpressure then toggled next
    start_txn(1);
    done_txn('{4, 0, 5, 1, 3, 2});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_index", int'(out_index), 4);
    end
    drain(1, n);

    // random transactions, some with out-of-range values
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_txn(2'($urandom_range(0, 3)));
      d = $urandom_range(0, TMO - 1);
      repeat (d) tick();
      for (int i = 0; i < 6; i++) v[i] = $urandom_range(0, 5);
      bad = $urandom_range(0, 4) == 0;
      if (bad) v[$urandom_range(0, 5)] = $urandom_range(6, 7);
      done_txn(v);
      if (!bad) drain(1, n);
    end

    // timeout
    start_txn(0);
    n = 0;
    while (scr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_ready_cycles", n, TMO);
    chk("timeout_err", int'(err), 1);
    chk("timeout_busy", int'(busy), 0);
    start_txn(3);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(scr_ready), 0);

    // range error
    start_txn(1);
    done_txn('{1, 2, 7, 3, 4, 0});
    rose = 0;
    repeat (5) begin
      tick();
      rose |= int'(out_valid);
    end
    chk("range_no_valid", rose, 0);
    chk("range_busy", int'(busy), 0);

    // abort and scr_done together
    start_txn(2);
    for (int i = 0; i < 6; i++) si[i] = 3'(i);
    scr_done = 1;
    abort = 1;
    tick();
    scr_done = 0;
    abort = 0;
    chk("abortdone_busy", int'(busy), 0);
    chk("abortdone_ready", int'(scr_ready), 0);
    chk("abortdone_err", int'(err), 0);
    rose = 0;
    repeat (3) begin
      tick();
      rose |= int'(out_valid);
    end
    chk("abortdone_no_valid", rose, 0);

    // start during DELIVER is ignored
    start_txn(0);
    done_txn('{5, 4, 3, 2, 1, 0});
    next = 1;
    tick();
    next = 0;
    chk("deliver_step", int'(out_index), 4);
    start = 1;
    tick();
    start = 0;
    chk("ignstart_index", int'(out_index), 4);
    chk("ignstart_valid", int'(out_valid), 1);
    chk("ignstart_ready", int'(scr_ready), 0);
    drain(0, n);
    chk("ignstart_remaining", n, 5);

    // scr_done on the timeout cycle
    start_txn(3);
    repeat (TMO - 1) tick();
    chk("edge_ready", int'(scr_ready), 1);
    done_txn('{0, 1, 2, 3, 4, 5});
    drain(0, n);

    // reset while delivering at slot 3
    start_txn(1);
    done_txn('{2, 3, 4, 5, 0, 1});
    repeat (3) begin
      next = 1;
      tick();
    end
    next = 0;
    chk("ptr3_index", int'(out_index), 5);
    rst = 1;
    tick();
    chk_zero("midreset");
    exp_q.delete();
    rst = 0;
    start = 1;
    mode_in = 2;
    tick();
    start = 0;
    chk("seed_restart", int'(scr_index), 0);
    chk("seed_restart_mode", int'(scr_mode), 2);
    abort = 1;
    tick();
    abort = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
